// File: rtl/sme_matcher_if.sv
// Handshake and data bundle between the string buffer (master) and the SME matcher (slave).
// str is not latched by the matcher and must stay stable while busy is high.
interface sme_matcher_if #(
  parameter int STR_DEPTH = 40,
  parameter int PAT_DEPTH = 8,
  parameter int IDX_W     = 5
);
  logic                          start;
  logic [5:0]                    slen;
  logic [STR_DEPTH-1:0][7:0]     str;
  logic [PAT_DEPTH-1:0][7:0]     pat;
  logic [3:0]                    plen;
  logic                          busy;
  logic                          valid;
  logic                          match;
  logic [IDX_W-1:0]              match_index;

  modport master (
    output start, slen, str, pat, plen,
    input  busy, valid, match, match_index
  );

  modport slave (
    input  start, slen, str, pat, plen,
    output busy, valid, match, match_index
  );
endinterface

// File: rtl/sme_matcher.sv
// SME matcher: leftmost search of a short pattern ('.', leading '^', trailing '$')
// over the sentinel-framed string buffer, one character compare per cycle.
//
// state | meaning
// IDLE  | waiting for start; request latched on the accept cycle
// SETUP | s=1, k=0; empty pattern or empty string goes straight to DONE
// CMP   | compare e[k] against str[s+k]
// NEXT  | advance start position s, restart at k=0
// DONE  | one-cycle valid strobe with match/match_index
module sme_matcher #(
  parameter int STR_DEPTH = 40,
  parameter int PAT_DEPTH = 8,
  parameter int IDX_W     = 5
) (
  input  logic         clk,
  input  logic         rst,
  sme_matcher_if.slave bus
);

  localparam int PW = $clog2(PAT_DEPTH);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SETUP = 3'd1,
    CMP   = 3'd2,
    NEXT  = 3'd3,
    DONE  = 3'd4
  } state_t;

  state_t                    state_q, state_d;
  logic [5:0]                slen_q;
  logic [PAT_DEPTH-1:0][7:0] pat_q;
  logic                      hat_q, dol_q;
  logic [3:0]                m_q;
  logic [5:0]                s_q, s_d;
  logic [5:0]                k_q, k_d;
  logic                      match_q, match_d;
  logic [IDX_W-1:0]          idx_q, idx_d;

  logic                      accept;
  logic                      acc_hat, acc_dol;
  logic [3:0]                plen_m1, anchors, acc_m;

  logic [6:0]                sk, s_prev, s_end, s_inc;
  logic [3:0]                eidx;
  logic [7:0]                e_ch;
  logic                      fail_bound, fail_hat, fail_chr;
  logic                      cmp_pass, cmp_last, end_ok;

  // Out-of-range reads return a space; the bound check always rejects them first anyway.
  function automatic logic [7:0] str_at(input logic [STR_DEPTH-1:0][7:0] a,
                                        input logic [6:0] idx);
    if (idx < 7'(STR_DEPTH))
      str_at = a[idx[5:0]];
    else
      str_at = 8'h20;
  endfunction

  assign accept  = (state_q == IDLE) && bus.start;
  assign acc_hat = (bus.pat[0] == 8'h5E);
  assign plen_m1 = bus.plen - 4'd1;
  assign acc_dol = (bus.plen != 4'd0) && (plen_m1 < 4'(PAT_DEPTH)) &&
                   (bus.pat[plen_m1[PW-1:0]] == 8'h24);
  assign anchors = {3'b000, acc_hat} + {3'b000, acc_dol};
  assign acc_m   = (bus.plen < anchors) ? 4'd0 : bus.plen - anchors;

  always_comb begin
    sk         = {1'b0, s_q} + {1'b0, k_q};
    s_prev     = {1'b0, s_q} - 7'd1;
    s_end      = {1'b0, s_q} + {3'b000, m_q};
    s_inc      = {1'b0, s_q} + 7'd1;
    eidx       = k_q[3:0] + {3'b000, hat_q};
    e_ch       = (eidx < 4'(PAT_DEPTH)) ? pat_q[eidx[PW-1:0]] : 8'h00;
    fail_bound = (sk >= {1'b0, slen_q});
    fail_hat   = (k_q == 6'd0) && hat_q && (str_at(bus.str, s_prev) != 8'h20);
    fail_chr   = (e_ch != 8'h2E) && (e_ch != str_at(bus.str, sk));
    cmp_pass   = !(fail_bound || fail_hat || fail_chr);
    cmp_last   = (k_q == ({2'b00, m_q} - 6'd1));
    end_ok     = !dol_q || (s_end == {1'b0, slen_q}) ||
                 (str_at(bus.str, s_end) == 8'h20);
  end

  always_comb begin
    state_d = state_q;
    s_d     = s_q;
    k_d     = k_q;
    match_d = match_q;
    idx_d   = idx_q;
    case (state_q)
      IDLE: begin
        if (bus.start) state_d = SETUP;
      end
      SETUP: begin
        s_d = 6'd1;
        k_d = 6'd0;
        if ((m_q == 4'd0) || (slen_q <= 6'd1)) begin
          state_d = DONE;
          match_d = 1'b0;
          idx_d   = '0;
        end else begin
          state_d = CMP;
        end
      end
      CMP: begin
        if (cmp_pass && !cmp_last) begin
          k_d = k_q + 6'd1;
        end else if (cmp_pass && end_ok) begin
          state_d = DONE;
          match_d = 1'b1;
          idx_d   = IDX_W'(s_q - 6'd1);
        end else begin
          state_d = NEXT;
        end
      end
      NEXT: begin
        s_d = s_inc[5:0];
        k_d = 6'd0;
        if (s_inc >= {1'b0, slen_q}) begin
          state_d = DONE;
          match_d = 1'b0;
          idx_d   = '0;
        end else begin
          state_d = CMP;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      s_q     <= '0;
      k_q     <= '0;
      match_q <= 1'b0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      s_q     <= s_d;
      k_q     <= k_d;
      match_q <= match_d;
      idx_q   <= idx_d;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      slen_q <= '0;
      pat_q  <= '0;
      hat_q  <= 1'b0;
      dol_q  <= 1'b0;
      m_q    <= '0;
    end else if (accept) begin
      slen_q <= bus.slen;
      pat_q  <= bus.pat;
      hat_q  <= acc_hat;
      dol_q  <= acc_dol;
      m_q    <= acc_m;
    end
  end

  assign bus.busy        = (state_q == SETUP) || (state_q == CMP) || (state_q == NEXT);
  assign bus.valid       = (state_q == DONE);
  assign bus.match       = match_q;
  assign bus.match_index = idx_q;

endmodule

// File: tb/tb_sme_matcher.sv
// Self-checking bench for sme_matcher: directed spec cases, busy/start interaction,
// mid-search reset and randomized searches against a behavioural reference.
module tb_sme_matcher;

  localparam int STR_DEPTH = 40;
  localparam int PAT_DEPTH = 8;
  localparam int TMO       = 2000;

  typedef struct {
    logic       m;
    logic [4:0] idx;
    int         lat;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;

  sme_matcher_if #(.STR_DEPTH(STR_DEPTH), .PAT_DEPTH(PAT_DEPTH), .IDX_W(5)) bus ();

  sme_matcher #(.STR_DEPTH(STR_DEPTH), .PAT_DEPTH(PAT_DEPTH), .IDX_W(5)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  logic [7:0] t_str [STR_DEPTH];
  int         t_slen;
  logic [7:0] t_pat [PAT_DEPTH];
  int         t_plen;
  exp_t       sb[$];
  int         checks = 0;
  int         passed = 0;

  task automatic set_str(input string s);
    for (int i = 0; i < STR_DEPTH; i++) t_str[i] = 8'h7A;
    for (int i = 0; i < s.len(); i++) t_str[i] = s[i];
    t_slen = s.len() - 1;
  endtask

  task automatic set_pat(input string p);
    for (int i = 0; i < PAT_DEPTH; i++) t_pat[i] = 8'h00;
    for (int i = 0; i < p.len(); i++) t_pat[i] = p[i];
    t_plen = p.len();
  endtask

  task automatic apply();
    for (int i = 0; i < STR_DEPTH; i++) bus.str[i] = t_str[i];
    for (int i = 0; i < PAT_DEPTH; i++) bus.pat[i] = t_pat[i];
    bus.slen = 6'(t_slen);
    bus.plen = 4'(t_plen);
  endtask

  // Straightforward leftmost search; latency counts clock edges from the accept edge
  // to the edge that raises valid.
  task automatic ref_model(output exp_t e);
    int hat, dol, m;
    bit ok;
    hat = (t_pat[0] == 8'h5E) ? 1 : 0;
    dol = (t_pat[t_plen-1] == 8'h24) ? 1 : 0;
    m = t_plen - hat - dol;
    e.m = 1'b0;
    e.idx = 5'd0;
    e.lat = 2;
    if (m <= 0 || t_slen <= 1) return;
    for (int s = 1; s < t_slen; s++) begin
      ok = 1'b1;
      for (int k = 0; k < m; k++) begin
        e.lat++;
        if (s + k >= t_slen) ok = 1'b0;
        else if (k == 0 && hat == 1 && t_str[s-1] != 8'h20) ok = 1'b0;
        else if (t_pat[k+hat] != 8'h2E && t_pat[k+hat] != t_str[s+k]) ok = 1'b0;
        if (!ok) break;
      end
      if (ok && dol == 1 && (s + m) != t_slen && t_str[s+m] != 8'h20) ok = 1'b0;
      if (ok) begin
        e.m = 1'b1;
        e.idx = 5'(s - 1);
        return;
      end
      e.lat++;
    end
  endtask

  task automatic search(output logic m, output logic [4:0] ix, output int lat,
                        output bit tmo);
    @(negedge clk);
    apply();
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    lat = 1;
    tmo = 1'b0;
    while (bus.valid !== 1'b1) begin
      if (lat >= TMO) begin
        tmo = 1'b1;
        break;
      end
      @(negedge clk);
      lat++;
    end
    m  = bus.match;
    ix = bus.match_index;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    bus.start = 1'b0;
    set_str(" abc def ");
    set_pat("def");
    apply();
    repeat (3) @(negedge clk);
    checks++;
    if (bus.busy !== 1'b0) $display("FAIL reset_busy got=%b exp=0", bus.busy);
    else passed++;
    checks++;
    if (bus.valid !== 1'b0) $display("FAIL reset_valid got=%b exp=0", bus.valid);
    else passed++;
    checks++;
    if (bus.match !== 1'b0) $display("FAIL reset_match got=%b exp=0", bus.match);
    else passed++;
    checks++;
    if (bus.match_index !== 5'd0) $display("FAIL reset_index got=%0d exp=0", bus.match_index);
    else passed++;
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_directed();
    string pats [8]  = '{"def", "^de", "^ef", "c$", "b$", ".b.", "f..", "^$"};
    logic  exp_m [8] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    int    exp_i [8] = '{4, 4, 0, 2, 0, 0, 0, 0};
    exp_t  e, ref_e;
    logic  m;
    logic [4:0] ix;
    int    lat;
    bit    tmo;
    set_str(" abc def ");
    for (int i = 0; i < 8; i++) begin
      set_pat(pats[i]);
      ref_model(ref_e);
      e.m = exp_m[i];
      e.idx = 5'(exp_i[i]);
      e.lat = (i == 7) ? 2 : ((i == 5) ? 5 : ref_e.lat);
      sb.push_back(e);
      search(m, ix, lat, tmo);
      e = sb.pop_front();
      checks++;
      if (tmo) $display("FAIL dir_timeout pat=%s no valid within %0d cycles", pats[i], TMO);
      else passed++;
      checks++;
      if (m !== e.m) $display("FAIL dir_match pat=%s got=%b exp=%b", pats[i], m, e.m);
      else passed++;
      checks++;
      if (ix !== e.idx) $display("FAIL dir_index pat=%s got=%0d exp=%0d", pats[i], ix, e.idx);
      else passed++;
      checks++;
      if (lat != e.lat) $display("FAIL dir_latency pat=%s got=%0d exp=%0d", pats[i], lat, e.lat);
      else passed++;
    end
  endtask

  task automatic test_start_while_busy();
    exp_t e;
    int   lat, extra;
    bit   tmo;
    set_str(" abc def ");
    set_pat("f..");
    ref_model(e);
    sb.push_back(e);
    @(negedge clk);
    apply();
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    lat = 1;
    checks++;
    if (bus.busy !== 1'b1) $display("FAIL busy_after_start got=%b exp=1", bus.busy);
    else passed++;
    checks++;
    if (bus.valid !== 1'b0) $display("FAIL valid_after_start got=%b exp=0", bus.valid);
    else passed++;
    @(negedge clk);
    lat++;
    set_pat(".b.");
    apply();
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    lat++;
    tmo = 1'b0;
    while (bus.valid !== 1'b1) begin
      if (lat >= TMO) begin
        tmo = 1'b1;
        break;
      end
      @(negedge clk);
      lat++;
    end
    e = sb.pop_front();
    checks++;
    if (tmo) $display("FAIL busy_timeout no valid within %0d cycles", TMO);
    else passed++;
    checks++;
    if (bus.match !== e.m) $display("FAIL busy_ignore_match got=%b exp=%b", bus.match, e.m);
    else passed++;
    checks++;
    if (lat != e.lat) $display("FAIL busy_ignore_latency got=%0d exp=%0d", lat, e.lat);
    else passed++;
    checks++;
    if (bus.busy !== 1'b0) $display("FAIL busy_at_valid got=%b exp=0", bus.busy);
    else passed++;
    // start asserted during the DONE cycle must also be dropped
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    extra = 0;
    for (int i = 0; i < 8; i++) begin
      if (bus.valid === 1'b1 || bus.busy === 1'b1) extra++;
      @(negedge clk);
    end
    checks++;
    if (extra != 0) $display("FAIL ignored_start_activity got=%0d exp=0", extra);
    else passed++;
  endtask

  task automatic test_reset_mid();
    exp_t e;
    logic m;
    logic [4:0] ix;
    int   lat, seen;
    bit   tmo;
    set_str(" abc def ");
    set_pat(".b.");
    search(m, ix, lat, tmo);
    checks++;
    if (m !== 1'b1 || tmo) $display("FAIL pre_reset_match got=%b exp=1", m);
    else passed++;
    set_pat("zz");
    @(negedge clk);
    apply();
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b0;
    #1;
    checks++;
    if (bus.busy !== 1'b0) $display("FAIL midrst_busy got=%b exp=0", bus.busy);
    else passed++;
    checks++;
    if (bus.valid !== 1'b0) $display("FAIL midrst_valid got=%b exp=0", bus.valid);
    else passed++;
    checks++;
    if (bus.match !== 1'b0) $display("FAIL midrst_match got=%b exp=0", bus.match);
    else passed++;
    @(negedge clk);
    rst = 1'b1;
    seen = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (bus.valid === 1'b1) seen++;
    end
    checks++;
    if (seen != 0) $display("FAIL midrst_stray_valid got=%0d exp=0", seen);
    else passed++;
    set_pat("c$");
    ref_model(e);
    e.m = 1'b1;
    e.idx = 5'd2;
    sb.push_back(e);
    search(m, ix, lat, tmo);
    e = sb.pop_front();
    checks++;
    if (tmo || m !== e.m || ix !== e.idx)
      $display("FAIL post_reset_search got=%b/%0d exp=%b/%0d", m, ix, e.m, e.idx);
    else passed++;
  endtask

  task automatic test_random();
    string al_s = "ab ";
    string al_p = "ab.";
    exp_t  e;
    logic  m;
    logic [4:0] ix;
    int    lat;
    bit    tmo;
    for (int n = 0; n < 30; n++) begin
      for (int i = 0; i < STR_DEPTH; i++) t_str[i] = 8'h7A;
      t_slen = $urandom_range(2, STR_DEPTH - 1);
      t_str[0] = 8'h20;
      for (int i = 1; i < t_slen; i++) t_str[i] = al_s[$urandom_range(0, 2)];
      t_str[t_slen] = 8'h20;
      for (int i = 0; i < PAT_DEPTH; i++) t_pat[i] = 8'h00;
      t_plen = $urandom_range(1, PAT_DEPTH);
      for (int i = 0; i < t_plen; i++) t_pat[i] = al_p[$urandom_range(0, 2)];
      if ($urandom_range(0, 2) == 0) t_pat[0] = 8'h5E;
      if ($urandom_range(0, 2) == 0) t_pat[t_plen-1] = 8'h24;
      ref_model(e);
      sb.push_back(e);
      search(m, ix, lat, tmo);
      e = sb.pop_front();
      checks++;
      if (tmo || m !== e.m || ix !== e.idx || lat != e.lat)
        $display("FAIL rand_%0d got=%b/%0d/%0d exp=%b/%0d/%0d slen=%0d plen=%0d",
                 n, m, ix, lat, e.m, e.idx, e.lat, t_slen, t_plen);
      else passed++;
    end
  endtask

  initial begin
    bus.start = 1'b0;
    test_reset();
    test_directed();
    test_start_while_busy();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
